// File: rtl/parallel_input_sampler_pkg.sv
// -----------------------------------------------------------------------------
// parallel_input_sampler_pkg
// Purpose : shared parameter-range limits, reset defaults and a counter-width
//           helper for the parallel input sampler and its debounce sub-block.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package parallel_input_sampler_pkg;

    localparam int MAX_WIDTH               = 32;
    localparam int MIN_SYNC_STAGES         = 2;
    localparam int DEFAULT_WIDTH           = 32;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

    // Counter must be able to hold the value DEBOUNCE_CYCLES itself.
    function automatic int debounce_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/parallel_input_sampler_if.sv
// -----------------------------------------------------------------------------
// parallel_input_sampler_if
// Purpose : groups the pad-side inputs and status/control-side signals of the
//           parallel input sampler.
// Signals : in_bits    - asynchronous input lines
//           bus        - synchronised (and filtered) line state
//           rise_flags - sticky 0->1 events      fall_flags - sticky 1->0 events
//           clear_rise - per-bit clear pulse     clear_fall - per-bit clear pulse
//           irq_mask   - per-bit irq enable      irq        - registered interrupt
// Modports: master (register block / bench side), slave (sampler side).
// -----------------------------------------------------------------------------
interface parallel_input_sampler_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] in_bits;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] rise_flags;
    logic [WIDTH-1:0] fall_flags;
    logic [WIDTH-1:0] clear_rise;
    logic [WIDTH-1:0] clear_fall;
    logic [WIDTH-1:0] irq_mask;
    logic             irq;

    modport master (
        output in_bits, clear_rise, clear_fall, irq_mask,
        input  bus, rise_flags, fall_flags, irq
    );

    modport slave (
        input  in_bits, clear_rise, clear_fall, irq_mask,
        output bus, rise_flags, fall_flags, irq
    );
endinterface

// File: rtl/parallel_input_sampler_debounce_bit.sv
// -----------------------------------------------------------------------------
// sampler_debounce_bit
// Purpose : single-line debounce filter. The stable state only follows the
//           synchronised input after it has differed for DEBOUNCE_CYCLES
//           consecutive cycles.
// Ports   : clk, rst       - clock, synchronous active-high reset
//           i_sync         - synchronised input line
//           o_state        - registered debounced state
//           o_state_next   - value o_state takes on the next edge (for edge detect)
// -----------------------------------------------------------------------------
module sampler_debounce_bit
    import parallel_input_sampler_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sync,
    output logic o_state,
    output logic o_state_next
);
    localparam int            CW       = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic          r_state;
    logic          w_state_next;

    // The cycle on which the count would reach DEBOUNCE_CYCLES is the toggle
    // cycle, so compare against DEBOUNCE_CYCLES-1 and restart from zero.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = '0;
        if (i_sync != r_state) begin
            if (r_cnt == CNT_LAST) begin
                w_state_next = i_sync;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_state <= RESET_BIT;
        end else begin
            r_cnt   <= w_cnt_next;
            r_state <= w_state_next;
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_next;
endmodule

// File: rtl/parallel_input_sampler.sv
// -----------------------------------------------------------------------------
// parallel_input_sampler
// Purpose : samples WIDTH asynchronous lines through SYNC_STAGES flops, presents
//           them as a registered bus, latches sticky rise/fall events with
//           per-bit clear (set beats clear) and drives a masked, registered irq.
// Ports   : clk  - system clock
//           rst  - synchronous reset, active-high
//           sif  - parallel_input_sampler_if.slave (in_bits, bus, flags,
//                  clears, irq_mask, irq)
// Build   : define PARALLEL_INPUT_SAMPLER_DEBOUNCE_EN to insert a per-bit
//           debounce filter (sampler_debounce_bit) between sync chain and bus.
// -----------------------------------------------------------------------------
module parallel_input_sampler
    import parallel_input_sampler_pkg::*;
#(
    parameter int               WIDTH           = DEFAULT_WIDTH,
    parameter int               SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE     = DEFAULT_RESET_VALUE[WIDTH-1:0],
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    parallel_input_sampler_if.slave  sif
);
    // Elaboration-time parameter range checks.
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("parallel_input_sampler: WIDTH out of range");
    end
    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("parallel_input_sampler: SYNC_STAGES too small");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("parallel_input_sampler: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync_out;
    logic [WIDTH-1:0] w_bus;
    logic [WIDTH-1:0] w_bus_next;
    logic [WIDTH-1:0] w_rise_set;
    logic [WIDTH-1:0] w_fall_set;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_irq;

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= sif.in_bits;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef PARALLEL_INPUT_SAMPLER_DEBOUNCE_EN
    // The debounce flop is the bus flop; its next value feeds edge detection.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_debounce
        sampler_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VALUE[gi])
        ) u_debounce (
            .clk          (clk),
            .rst          (rst),
            .i_sync       (w_sync_out[gi]),
            .o_state      (w_bus[gi]),
            .o_state_next (w_bus_next[gi])
        );
    end
`else
    logic [WIDTH-1:0] r_bus;

    assign w_bus_next = w_sync_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus <= RESET_VALUE;
        end else begin
            r_bus <= w_bus_next;
        end
    end

    assign w_bus = r_bus;
`endif

    // Events are judged on next vs current bus so the flag sets on the same
    // edge the bus bit changes. Flags are forced to zero during reset, so the
    // reset itself never reports an edge.
    assign w_rise_set = w_bus_next & ~w_bus;
    assign w_fall_set = ~w_bus_next & w_bus;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= '0;
            r_fall <= '0;
            r_irq  <= 1'b0;
        end else begin
            // OR-ing the set term last makes a colliding set win over clear.
            r_rise <= (r_rise & ~sif.clear_rise) | w_rise_set;
            r_fall <= (r_fall & ~sif.clear_fall) | w_fall_set;
            r_irq  <= |((r_rise | r_fall) & sif.irq_mask);
        end
    end

    assign sif.bus        = w_bus;
    assign sif.rise_flags = r_rise;
    assign sif.fall_flags = r_fall;
    assign sif.irq        = r_irq;
endmodule
